reg_wb_queue: RTL and testbench
===============================

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 in_valid  in  1  writeback request valid from the execute/load side.
REQ-004 in_ready  out  1  queue can accept a request this cycle.
REQ-005 in_rd  in  5  destination register index of the request.
REQ-006 in_data  in  32  result value of the request.
REQ-007 wb_hold  in  1  register write port unavailable this cycle; freeze drain.
REQ-008 we  out  1  register-file write enable.
REQ-009 waddr  out  5  register-file write index.
REQ-010 wdata  out  32  register-file write data.
REQ-011 qaddr1, qaddr2  in  5 each  decode-stage source indices for hazard query.
REQ-012 qbusy1, qbusy2  out  1 each  a pending write targets qaddr1 / qaddr2.
REQ-013 occupancy  out  3  number of queued entries, 0..4.
REQ-014 qfwd_data1, qfwd_data2  out  32 each  forwarded pending value; present only with REG_WB_BYPASS_EN.

Function
REQ-015 Storage SHALL be a 4-entry FIFO of {rd[4:0], data[31:0]}, with 2-bit read and write pointers that wrap from 3 to 0 and a 3-bit count.
REQ-016 in_ready SHALL be 1 when count < 4, derived from registered count only, with no combinational path from wb_hold.
REQ-017 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 An accepted request with in_rd=0 SHALL be consumed and discarded: it is not enqueued and never produces we=1.
REQ-019 The FIFO head SHALL drive the write port combinationally: we = (count!=0) & ~wb_hold, waddr = head rd, wdata = head data.
REQ-020 When we=1, the head SHALL be popped at that rising edge.
REQ-021 Minimum latency SHALL be one cycle: a request accepted at edge N into an empty queue appears with we=1 in cycle N+1, if wb_hold=0.
REQ-022 Writes SHALL reach the register file in acceptance order; duplicate rd entries are all written, oldest first.
REQ-023 Simultaneous accept and pop SHALL leave count unchanged; accept at count=4 SHALL NOT occur even if a pop happens that cycle.
REQ-024 When count=0, waddr and wdata SHALL be 0 and we SHALL be 0.
REQ-025 qbusyN SHALL be 1 if qaddrN!=0 and any valid entry has rd==qaddrN; otherwise it SHALL be 0.
REQ-026 qbusyN SHALL be purely combinational on qaddrN and queue state, and SHALL NOT include the request currently presented on in_*.

Reset
REQ-027 While rst=1, pointers and count SHALL be 0, and we, occupancy, qbusy1 and qbusy2 SHALL be 0; this takes effect immediately, without waiting for a clock edge.
REQ-028 Reset mid-operation SHALL discard all pending entries with no partial write, and in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 Data storage SHALL NOT require reset.

Configuration
REQ-030 Macro REG_WB_BYPASS_EN defined: qfwd_dataN SHALL equal the data of the youngest valid entry with rd==qaddrN when qbusyN=1, and 0 otherwise.
REQ-031 REG_WB_BYPASS_EN undefined: qfwd_data1 and qfwd_data2 and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then in_valid with rd=5, data=0x12345678 at edge 1 -> cycle 2: we=1, waddr=5, wdata=0x12345678; cycle 3: we=0, occupancy=0.
REQ-033 wb_hold=1, push rd=1..4 with data 0x11..0x44 -> occupancy=4, in_ready=0, rd=6 is not accepted; release wb_hold -> writes 1,2,3,4 on consecutive cycles, then in_ready=1.
REQ-034 Push rd=0, data=0xDEAD -> accepted (in_ready=1), occupancy stays 0, we never asserted.
REQ-035 wb_hold=1, push rd=7/0xA then rd=7/0xB, qaddr1=7, qaddr2=0 -> qbusy1=1, qbusy2=0; with REG_WB_BYPASS_EN, qfwd_data1=0xB.
REQ-036 Count=3, with pop and push in the same cycle -> count remains 3; assert rst asynchronously mid-drain -> we=0 within the same cycle, occupancy=0, and no further writes after release.

Source files
------------

// File: rtl/reg_wb_queue.sv
// reg_wb_queue
//   Four-entry writeback queue that sits between the execute/load side and
//   the register-file write port. Requests are drained in acceptance order.
//   Writes to x0 are accepted and dropped. A decode-stage hazard query
//   reports whether a source register still has a pending write.
//
// Optional feature (macro REG_WB_BYPASS_EN):
//   Adds qfwd_data1/qfwd_data2, which carry the youngest pending value for
//   qaddr1/qaddr2. Without the macro, those ports and their logic are absent.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_rd, in_data        request destination index and value
//   wb_hold               write port busy this cycle; the drain is frozen
//   we, waddr, wdata      register-file write port, driven from the FIFO head
//   qaddr1/2, qbusy1/2    hazard query: a pending write targets qaddrN
//   qfwd_data1/2          forwarded pending value (REG_WB_BYPASS_EN only)
//   occupancy             number of queued entries, 0..4
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the registered count, never
// on wb_hold or in_valid, so a full queue refuses requests even in a cycle
// where it is also popping.
module reg_wb_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  input  logic        wb_hold,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  qaddr1,
  input  logic [4:0]  qaddr2,
  output logic        qbusy1,
  output logic        qbusy2,
`ifdef REG_WB_BYPASS_EN
  output logic [31:0] qfwd_data1,
  output logic [31:0] qfwd_data2,
`endif
  output logic [2:0]  occupancy
);

  // Storage carries no reset: an entry is only ever read while count says
  // it is valid.
  logic [4:0]  mem_rd   [4];
  logic [31:0] mem_data [4];

  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;

  logic accept;
  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count != 3'd0);
  assign in_ready  = (count < 3'd4);
  assign accept    = in_valid & in_ready;
  // Writes to x0 complete the handshake but never occupy an entry.
  assign push      = accept & (in_rd != 5'd0);
  assign we        = not_empty & ~wb_hold;
  assign pop       = we;

  assign waddr     = not_empty ? mem_rd[rptr]   : 5'd0;
  assign wdata     = not_empty ? mem_data[rptr] : 32'd0;
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr]   <= in_rd;
      mem_data[wptr] <= in_data;
    end
  end

  // Walk entries oldest to youngest so that, with forwarding enabled, the
  // last match seen is the youngest pending value for that register.
  always_comb begin
    logic [1:0] idx;
    idx    = 2'd0;
    qbusy1 = 1'b0;
    qbusy2 = 1'b0;
`ifdef REG_WB_BYPASS_EN
    qfwd_data1 = 32'd0;
    qfwd_data2 = 32'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = rptr + 2'(k);
      if (3'(k) < count) begin
        if ((qaddr1 != 5'd0) && (mem_rd[idx] == qaddr1)) begin
          qbusy1 = 1'b1;
`ifdef REG_WB_BYPASS_EN
          qfwd_data1 = mem_data[idx];
`endif
        end
        if ((qaddr2 != 5'd0) && (mem_rd[idx] == qaddr2)) begin
          qbusy2 = 1'b1;
`ifdef REG_WB_BYPASS_EN
          qfwd_data2 = mem_data[idx];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue
//   Bench for reg_wb_queue. The reference model is a plain queue of
//   {rd, data} pairs: pushes append non-zero-rd requests while fewer than
//   four are held, a write pops the front whenever the queue is non-empty
//   and wb_hold is low, and hazard answers come from scanning the queue.
module tb_reg_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  qaddr1;
  logic [4:0]  qaddr2;
  logic        qbusy1;
  logic        qbusy2;
  logic [2:0]  occupancy;
`ifdef REG_WB_BYPASS_EN
  logic [31:0] qfwd_data1;
  logic [31:0] qfwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];

  reg_wb_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .wb_hold    (wb_hold),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .qaddr1     (qaddr1),
    .qaddr2     (qaddr2),
    .qbusy1     (qbusy1),
    .qbusy2     (qbusy2),
`ifdef REG_WB_BYPASS_EN
    .qfwd_data1 (qfwd_data1),
    .qfwd_data2 (qfwd_data2),
`endif
    .occupancy  (occupancy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic hold);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wb_hold  = hold;
  endtask

  task automatic query(input logic [4:0] a1, input logic [4:0] a2);
    qaddr1 = a1;
    qaddr2 = a2;
  endtask

  // One cycle: compare all outputs against the model at the falling edge,
  // then advance the model with the inputs seen at the rising edge.
  task automatic tick();
    int          n;
    logic [36:0] head;
    logic        eb1;
    logic        eb2;
    logic [31:0] ef1;
    logic [31:0] ef2;
    @(negedge clk);
    n    = exp_q.size();
    head = (n != 0) ? exp_q[0] : 37'd0;
    eb1 = 1'b0; eb2 = 1'b0; ef1 = 32'd0; ef2 = 32'd0;
    foreach (exp_q[i]) begin
      if (qaddr1 != 5'd0 && exp_q[i][36:32] == qaddr1) begin eb1 = 1'b1; ef1 = exp_q[i][31:0]; end
      if (qaddr2 != 5'd0 && exp_q[i][36:32] == qaddr2) begin eb2 = 1'b1; ef2 = exp_q[i][31:0]; end
    end
    check("in_ready",  32'(in_ready),  32'(n < 4));
    check("occupancy", 32'(occupancy), 32'(n));
    check("we",        32'(we),        32'((n != 0) && !wb_hold));
    check("waddr",     32'(waddr),     32'(head[36:32]));
    check("wdata",     wdata,          head[31:0]);
    check("qbusy1",    32'(qbusy1),    32'(eb1));
    check("qbusy2",    32'(qbusy2),    32'(eb2));
`ifdef REG_WB_BYPASS_EN
    check("qfwd_data1", qfwd_data1, ef1);
    check("qfwd_data2", qfwd_data2, ef2);
`endif
    @(posedge clk);
    if (n != 0 && !wb_hold) void'(exp_q.pop_front());
    if (in_valid && n < 4 && in_rd != 5'd0) exp_q.push_back({in_rd, in_data});
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    query(5'd0, 5'd0);
    #2;
    check("rst_we",        32'(we),        32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_qbusy1",    32'(qbusy1),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Single request, one-cycle latency, then empty.
    drive(1'b1, 5'd5, 32'h12345678, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    #1 check("lat_we", 32'(we), 32'd1);
    check("lat_wdata", wdata, 32'h12345678);
    tick();
    tick();

    // Fill under hold, refuse while full, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 17), 1'b1);
      tick();
    end
    drive(1'b1, 5'd6, 32'h66, 1'b1);
    #1 check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    drive(1'b1, 5'd6, 32'h66, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();

    // Request to x0 is consumed without a write.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0);
    #1 check("x0_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();

    // Hazard query with duplicate destinations.
    drive(1'b1, 5'd7, 32'hA, 1'b1);
    tick();
    drive(1'b1, 5'd7, 32'hB, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    query(5'd7, 5'd0);
    #1 check("hz_qbusy1", 32'(qbusy1), 32'd1);
    check("hz_qbusy2", 32'(qbusy2), 32'd0);
`ifdef REG_WB_BYPASS_EN
    check("hz_fwd1", qfwd_data1, 32'hB);
`endif
    tick();
    drive(1'b1, 5'd9, 32'h99, 1'b1);
    tick();
    // Count 3: pop and push together keep it at 3.
    drive(1'b1, 5'd10, 32'hAA, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    #1 check("pp_occupancy", 32'(occupancy), 32'd3);

    // Asynchronous reset in the middle of the drain.
    #2 rst = 1'b1;
    #1 check("arst_we", 32'(we), 32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_qbusy1", 32'(qbusy1), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) == 0));
      query(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
